// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared widths, operand classes and stage bundles for fp_unpack_align
package fp_pkg;

  localparam int EXP_W      = 8;
  localparam int FRAC_W     = 23;
  localparam int GUARD_BITS = 8;
  localparam int MANT_W     = 32;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [2:0] {ZERO, SUBNORM, NORMAL, INF, NAN} fp_class_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant32;
    fp_class_t         cls;
  } fp_operand_t;

  typedef struct packed {
    logic [31:0]       word_a;
    logic [31:0]       word_b;
    logic              sign_a;
    logic              sign_b;
    logic              nan_a;
    logic              nan_b;
    logic              inf_a;
    logic              inf_b;
    logic              zero_a;
    logic              zero_b;
    logic [EXP_W-1:0]  exp_large;
    logic [MANT_W-1:0] mant_large;
    logic [MANT_W-1:0] mant_small;
    logic              large_sign;
    logic              eff_sub;
    logic              swapped;
  } stage_t;

  // Right shift by d; everything pushed past bit 0 collapses into a sticky bit.
  function automatic logic [MANT_W-1:0] align_sticky(input logic [MANT_W-1:0] m,
                                                     input logic [EXP_W-1:0]  d);
    logic [MANT_W-1:0] lost_mask;
    logic [MANT_W-1:0] res;
    lost_mask = '0;
    if (d >= EXP_W'(MANT_W)) begin
      res = {{(MANT_W-1){1'b0}}, |m};
    end else begin
      lost_mask = (MANT_W'(1) << d) - MANT_W'(1);
      res = (m >> d) | {{(MANT_W-1){1'b0}}, |(m & lost_mask)};
    end
    return res;
  endfunction

endpackage

// File: rtl/fp_operand_unpack.sv
// rtl/fp_operand_unpack.sv - combinational classification and field extraction of one binary32 word
module fp_operand_unpack
  import fp_pkg::*;
#(
  parameter int GUARD_BITS = fp_pkg::GUARD_BITS
) (
  input  logic [31:0]  word,
  output fp_operand_t  op
);

  logic [EXP_W-1:0]  exp_raw;
  logic [FRAC_W-1:0] frac;
  logic              hidden;

  assign exp_raw = word[30:23];
  assign frac    = word[22:0];
  assign hidden  = (exp_raw != '0);

  always_comb begin
    op.sign   = word[31];
    // Zeros and subnormals share the same 2^-126 scale, so both get exponent 1.
    op.exp    = hidden ? exp_raw : EXP_W'(1);
    op.mant32 = MANT_W'({hidden, frac}) << GUARD_BITS;
    if (exp_raw == EXP_MAX) begin
      op.cls = (frac != '0) ? NAN : INF;
    end else if (!hidden) begin
      op.cls = (frac != '0) ? SUBNORM : ZERO;
    end else begin
      op.cls = NORMAL;
    end
  end

endmodule

// File: rtl/fp_unpack_align.sv
// rtl/fp_unpack_align.sv - two-stage unpack, magnitude swap and sticky alignment of a binary32 pair
module fp_unpack_align
  import fp_pkg::*;
#(
  parameter int GUARD_BITS = fp_pkg::GUARD_BITS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        signA,
  output logic        signB,
  output logic        ANaN,
  output logic        BNaN,
  output logic        Ainf,
  output logic        Binf,
  output logic        Azero,
  output logic        Bzero,
  output logic [7:0]  exponentOut,
  output logic [31:0] mantLarge,
  output logic [31:0] mantSmall,
  output logic        largeSign,
  output logic        effSub,
  output logic        swapped,
  output logic [31:0] passA,
  output logic [31:0] passB
);

  fp_operand_t op_a;
  fp_operand_t op_b;

  fp_operand_unpack #(.GUARD_BITS(GUARD_BITS)) u_unpack_a (.word(A), .op(op_a));
  fp_operand_unpack #(.GUARD_BITS(GUARD_BITS)) u_unpack_b (.word(B), .op(op_b));

  logic             s1_valid;
  logic             s2_valid;
  stage_t           s1;
  stage_t           s2;
  logic [EXP_W-1:0] s1_shift;

  stage_t           s1_next;
  logic [EXP_W-1:0] shift_next;
  logic             swap;
  logic             s2_load;
  logic             s1_adv;
  logic             in_fire;

  assign s2_load  = !s2_valid || out_ready;
  assign s1_adv   = s1_valid && s2_load;
  assign in_ready = !s1_valid || s1_adv;
  assign in_fire  = in_valid && in_ready;

  // Exponent-then-fraction ordering equals an unsigned compare of the magnitude bits.
  assign swap = (B[30:0] > A[30:0]);

  always_comb begin
    s1_next            = '0;
    s1_next.word_a     = A;
    s1_next.word_b     = B;
    s1_next.sign_a     = op_a.sign;
    s1_next.sign_b     = op_b.sign;
    s1_next.nan_a      = (op_a.cls == NAN);
    s1_next.nan_b      = (op_b.cls == NAN);
    s1_next.inf_a      = (op_a.cls == INF);
    s1_next.inf_b      = (op_b.cls == INF);
    s1_next.zero_a     = (op_a.cls == ZERO);
    s1_next.zero_b     = (op_b.cls == ZERO);
    s1_next.swapped    = swap;
    s1_next.eff_sub    = op_a.sign ^ op_b.sign;
    s1_next.large_sign = swap ? op_b.sign   : op_a.sign;
    s1_next.exp_large  = swap ? op_b.exp    : op_a.exp;
    s1_next.mant_large = swap ? op_b.mant32 : op_a.mant32;
    s1_next.mant_small = swap ? op_a.mant32 : op_b.mant32;
    shift_next         = swap ? (op_b.exp - op_a.exp) : (op_a.exp - op_b.exp);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1       <= '0;
      s1_shift <= '0;
    end else begin
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1       <= s1_next;
        s1_shift <= shift_next;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2       <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2            <= s1;
        s2.mant_small <= align_sticky(s1.mant_small, s1_shift);
      end
    end
  end

  assign out_valid   = s2_valid;
  assign signA       = s2.sign_a;
  assign signB       = s2.sign_b;
  assign ANaN        = s2.nan_a;
  assign BNaN        = s2.nan_b;
  assign Ainf        = s2.inf_a;
  assign Binf        = s2.inf_b;
  assign Azero       = s2.zero_a;
  assign Bzero       = s2.zero_b;
  assign exponentOut = s2.exp_large;
  assign mantLarge   = s2.mant_large;
  assign mantSmall   = s2.mant_small;
  assign largeSign   = s2.large_sign;
  assign effSub      = s2.eff_sub;
  assign swapped     = s2.swapped;
  assign passA       = s2.word_a;
  assign passB       = s2.word_b;

endmodule

// File: tb/tb_fp_unpack_align.sv
// tb/tb_fp_unpack_align.sv - randomized and directed bench for fp_unpack_align against an arithmetic model
module tb_fp_unpack_align;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        signA, signB, ANaN, BNaN, Ainf, Binf, Azero, Bzero;
  logic [7:0]  exponentOut;
  logic [31:0] mantLarge, mantSmall, passA, passB;
  logic        largeSign, effSub, swapped;

  fp_unpack_align #(.GUARD_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
    .out_valid(out_valid), .out_ready(out_ready), .signA(signA), .signB(signB),
    .ANaN(ANaN), .BNaN(BNaN), .Ainf(Ainf), .Binf(Binf), .Azero(Azero), .Bzero(Bzero),
    .exponentOut(exponentOut), .mantLarge(mantLarge), .mantSmall(mantSmall),
    .largeSign(largeSign), .effSub(effSub), .swapped(swapped), .passA(passA), .passB(passB)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic [146:0] dut_bundle;
  assign dut_bundle = {signA, signB, ANaN, BNaN, Ainf, Binf, Azero, Bzero, exponentOut,
                       mantLarge, mantSmall, largeSign, effSub, swapped, passA, passB};

  typedef struct {
    logic [146:0] bundle;
    int           rdy;
  } exp_t;
  exp_t q[$];

  task automatic check(input string tag, input logic [146:0] got, input logic [146:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [146:0] ref_model(input logic [31:0] a, input logic [31:0] b);
    int          ea, eb, eff_a, eff_b, d;
    logic [31:0] ma, mb, ml, ms, al;
    logic [63:0] wide;
    logic        sw;
    ea    = int'(a[30:23]);
    eb    = int'(b[30:23]);
    eff_a = (ea == 0) ? 1 : ea;
    eff_b = (eb == 0) ? 1 : eb;
    ma    = ((ea != 0) ? 32'h8000_0000 : 32'h0) + {1'b0, a[22:0], 8'h00};
    mb    = ((eb != 0) ? 32'h8000_0000 : 32'h0) + {1'b0, b[22:0], 8'h00};
    sw    = (eb > ea) || ((eb == ea) && (b[22:0] > a[22:0]));
    d     = sw ? eff_b - eff_a : eff_a - eff_b;
    ml    = sw ? mb : ma;
    ms    = sw ? ma : mb;
    if (d >= 32) begin
      al = {31'b0, ms != 0};
    end else begin
      wide = {ms, 32'h0} >> d;
      al   = wide[63:32] | {31'b0, wide[31:0] != 0};
    end
    return {a[31], b[31],
            (ea == 255) && (a[22:0] != 0), (eb == 255) && (b[22:0] != 0),
            (ea == 255) && (a[22:0] == 0), (eb == 255) && (b[22:0] == 0),
            (ea == 0) && (a[22:0] == 0),   (eb == 0) && (b[22:0] == 0),
            8'(sw ? eff_b : eff_a), ml, al, sw ? b[31] : a[31], a[31] != b[31], sw, a, b};
  endfunction

  // One cycle: drive at negedge, then compare against the queued expectations.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b, input logic ordy);
    logic exp_vld;
    @(negedge clk);
    in_valid  = v;
    A         = a;
    B         = b;
    out_ready = ordy;
    #1;
    check("in_ready", in_ready, !(q.size() == 2 && !ordy));
    exp_vld = (q.size() > 0) && (cyc >= q[0].rdy);
    check("out_valid", out_valid, exp_vld);
    if (out_valid && q.size() > 0) check("bundle", dut_bundle, q[0].bundle);
    if (out_valid && ordy && q.size() > 0) begin
      void'(q.pop_front());
      if (q.size() > 0 && q[0].rdy < cyc + 1) q[0].rdy = cyc + 1;
    end
    if (v && in_ready) q.push_back('{ref_model(a, b), cyc + 2});
  endtask

  task automatic single(input logic [31:0] a, input logic [31:0] b);
    step(1'b1, a, b, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1);
    check("single_valid", out_valid, 1'b1);
  endtask

  function automatic logic [31:0] rand_op(input logic [31:0] ref_w);
    logic [31:0] specials [6];
    logic [7:0]  e;
    specials = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                 32'h7FC0_0000, 32'h7F80_0001};
    e = ref_w[30:23] + 8'($urandom_range(0, 40));
    case ($urandom_range(0, 5))
      0: return specials[$urandom_range(0, 5)];
      1: return {1'($urandom), e, 23'($urandom)};
      2: return {1'($urandom), 8'h00, 23'($urandom)};
      3: return {1'($urandom), ref_w[30:23], 23'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int seen;
    logic [31:0] ra, rb;

    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_mant_large", mantLarge, 32'h0);
    check("rst_exponent", exponentOut, 8'h0);
    @(negedge clk);
    rst_n = 1'b1;

    single(32'h3F80_0000, 32'h4000_0000);
    check("r30_swapped", swapped, 1'b1);
    check("r30_exp", exponentOut, 8'h80);
    check("r30_mant_large", mantLarge, 32'h8000_0000);
    check("r30_mant_small", mantSmall, 32'h4000_0000);
    check("r30_eff_sub", effSub, 1'b0);

    single(32'h3F80_0000, 32'h3380_0000);
    check("r31_mant_small", mantSmall, 32'h0000_0080);
    check("r31_exp", exponentOut, 8'h7F);
    check("r31_swapped", swapped, 1'b0);

    single(32'h4F80_0000, 32'h3F80_0001);
    check("r32_mant_small", mantSmall, 32'h0000_0001);
    check("r32_mant_large", mantLarge, 32'h8000_0000);

    single(32'h7FC0_0000, 32'hFF80_0000);
    check("r33_anan", ANaN, 1'b1);
    check("r33_binf", Binf, 1'b1);
    check("r33_eff_sub", effSub, 1'b1);
    check("r33_pass_a", passA, 32'h7FC0_0000);

    single(32'h0000_0001, 32'h0000_0000);
    check("r33_sub_mant", mantLarge, 32'h0000_0100);
    check("r33_sub_exp", exponentOut, 8'h01);
    check("r33_sub_bzero", Bzero, 1'b1);
    check("r33_sub_azero", Azero, 1'b0);

    // Backpressure: third pair must be refused while two are held.
    step(1'b1, 32'h3F80_0000, 32'h4000_0000, 1'b0);
    step(1'b1, 32'hC040_0000, 32'h3F00_0000, 1'b0);
    step(1'b1, 32'h4120_0000, 32'h0000_0003, 1'b0);
    check("bp_in_ready_low", in_ready, 1'b0);
    check("bp_held", q.size(), 2);
    seen = 0;
    step(1'b1, 32'h4120_0000, 32'h0000_0003, 1'b1);
    seen += int'(out_valid);
    step(1'b0, 32'h0, 32'h0, 1'b1);
    seen += int'(out_valid);
    step(1'b0, 32'h0, 32'h0, 1'b1);
    seen += int'(out_valid);
    check("bp_delivered", seen, 3);
    check("bp_empty", q.size(), 0);

    // Asynchronous reset with two pairs in flight.
    step(1'b1, 32'h4000_0000, 32'h3F80_0000, 1'b0);
    step(1'b1, 32'h4040_0000, 32'h3F80_0000, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_in_ready", in_ready, 1'b1);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 32'h4080_0000, 32'hBF80_0000, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1);
    check("arst_lat1", out_valid, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1);
    check("arst_lat2", out_valid, 1'b1);
    check("arst_pass_a", passA, 32'h4080_0000);

    for (int i = 0; i < 600; i++) begin
      ra = rand_op($urandom);
      rb = rand_op(ra);
      if ($urandom_range(0, 1) == 1) begin
        step(1'($urandom_range(0, 3) != 0), ra, rb, 1'($urandom_range(0, 9) < 7));
      end else begin
        step(1'($urandom_range(0, 3) != 0), rb, ra, 1'($urandom_range(0, 9) < 7));
      end
    end
    repeat (6) step(1'b0, 32'h0, 32'h0, 1'b1);
    check("drain", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_unpack_align.md
FP_UNPACK_ALIGN -- requirements
Module: fp_unpack_align

Interface
REQ-001 Parameter GUARD_BITS, default 8: number of guard/round/sticky bit positions below the mantissa LSB in the 32-bit mantissa fields.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operand pair A/B present.
REQ-005 in_ready  output  1  block accepts the pair this cycle.
REQ-006 A, B  input  32 each  IEEE-754 single-precision operands.
REQ-007 out_valid  output  1  output bundle valid.
REQ-008 out_ready  input  1  downstream (add/normalize) accepts the bundle.
REQ-009 signA, signB  output  1 each  operand signs.
REQ-010 ANaN, BNaN, Ainf, Binf, Azero, Bzero  output  1 each  operand class flags.
REQ-011 exponentOut  output  8  effective exponent of the larger-magnitude operand.
REQ-012 mantLarge  output  32  larger-magnitude mantissa, formatted as {hidden, frac[22:0], GUARD_BITS zeros}.
REQ-013 mantSmall  output  32  smaller mantissa, right-aligned, with the sticky bit ORed into bit 0.
REQ-014 largeSign, effSub, swapped  output  1 each  sign of the larger operand; signA!=signB; B is larger.
REQ-015 The outputs SHALL carry the A and B operand words unchanged, to support NaN/Inf passthrough downstream.

Function
REQ-016 Transfer rule: an input pair SHALL transfer when in_valid && in_ready; an output bundle SHALL transfer when out_valid && out_ready.
REQ-017 Pipeline structure: the block SHALL have two register stages.
  - S1 registers the unpacked fields, class flags, the swap decision and d = expLarge - expSmall.
  - S2 registers the aligned result.
  - Latency with no stall SHALL be 2 cycles, input transfer to out_valid.
REQ-018 Stage advance: a stage SHALL load when it is empty, or when its contents transfer onward in the same cycle.
  - in_ready = !s1_valid || s1 advancing.
  - Throughput SHALL be one pair per cycle.
REQ-019 Backpressure: with out_ready low, the block SHALL hold at most 2 pairs, deassert in_ready, and drop or reorder nothing.
REQ-020 Classification, per operand:
  - exp==FF, frac!=0 -> NaN.
  - exp==FF, frac==0 -> inf.
  - exp==0, frac==0 -> zero (either sign).
  - exp==0, frac!=0 -> subnormal: effective exponent 1, hidden bit 0.
  - otherwise -> normal: hidden bit 1.
REQ-021 Swap: B SHALL be larger when expB>expA, or when expB==expA and fracB>fracA; on full equality A SHALL be larger (swapped=0).
REQ-022 Alignment: mantSmall SHALL be the smaller mantissa shifted right by d, with bit 0 ORed with the OR of all bits shifted out.
REQ-023 Large difference: for d>=32, mantSmall SHALL be 31'b0 followed by the OR of the whole smaller mantissa.
REQ-024 Special operands: for NaN, inf or zero, fields SHALL still be computed by the same rules; the flags alone govern downstream special handling.
REQ-025 Output stability: outputs SHALL be register-driven and SHALL stay stable while out_valid && !out_ready.

Reset
REQ-026 While rst_n is low, s1_valid and s2_valid SHALL be 0 and all data registers 0, giving out_valid=0 and in_ready=1 immediately.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight pairs; the first transfer after release SHALL yield the first post-reset pair only.

Structure
REQ-028 Shared package fp_pkg SHALL hold:
  - EXP_W=8, FRAC_W=23, GUARD_BITS, EXP_MAX=8'hFF.
  - an fp_class_t enum {ZERO, SUBNORM, NORMAL, INF, NAN}.
  - an unpacked-operand struct (sign, exp, mant32, class).
REQ-029 One sub-module, fp_operand_unpack, SHALL perform combinational per-operand classification and field extraction, instantiated twice.

Verification
REQ-030 A=0x3F800000, B=0x40000000 -> 2 cycles later: swapped=1, exponentOut=0x80, mantLarge=0x80000000, mantSmall=0x40000000, effSub=0.
REQ-031 A=0x3F800000, B=0x33800000 (d=24) -> mantSmall=0x00000080, exponentOut=0x7F, swapped=0.
REQ-032 A=0x4F800000, B=0x3F800001 (d=32) -> mantSmall=0x00000001, mantLarge=0x80000000.
REQ-033 A=0x7FC00000, B=0xFF800000 -> ANaN=1, Binf=1, effSub=1; A=0x00000001 -> subnormal, mant=0x00000100, effective exponent 1.
REQ-034 Hold out_ready=0 while issuing 3 pairs back-to-back -> in_ready low after 2 accepted; release -> 3 bundles delivered in order, one per cycle.
REQ-035 Assert rst_n=0 with 2 pairs in flight -> out_valid=0 asynchronously; after release, the next pair appears after exactly 2 cycles.
